// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between instruction fetch and the data
// port (LW/SW/LL/SC). Owns the LL/SC link register and resolves SC outcome
// without touching RAM when the link is already broken.
module mem_arbiter (
   input  logic        CLK,
   input  logic        RST,
   // instruction port
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        iwait,
   output logic [31:0] iload,
   // data port
   input  logic        dREN,
   input  logic        dWEN,
   input  logic        datomic,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dwait,
   output logic [31:0] dload,
   // RAM port
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IFETCH  = 2'd1,
      DACCESS = 2'd2,
      SCFAIL  = 2'd3
   } state_t;

   localparam logic [1:0] RAM_ACCESS = 2'd2;

   state_t      state, next_state;
   logic        last_data;
   logic        link_valid;
   logic [31:0] link_addr;

   logic        dreq;
   logic        ram_done;
   logic        sc_link_ok;

   assign dreq       = dREN | dWEN;
   assign ram_done   = (ramstate == RAM_ACCESS);
   assign sc_link_ok = link_valid && (link_addr == daddr);

   // Waits are pure functions of the current grant and RAM completion.
   assign iwait = iREN & ~((state == IFETCH) & ram_done);
   assign dwait = dreq & ~(((state == DACCESS) & ram_done) | (state == SCFAIL));

   // State register; reset abandons any transfer in progress.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values of the others, independent of statement order.
   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= next_state;
   end

   // Fairness bit and LL/SC link, updated only when a grant completes.
   always_ff @(posedge CLK) begin
      if (RST) begin
         last_data  <= 1'b0;
         link_valid <= 1'b0;
         link_addr  <= 32'd0;
      end else begin
         case (state)
            IFETCH: begin
               if (ram_done) last_data <= 1'b0;
            end
            DACCESS: begin
               if (ram_done) begin
                  last_data <= 1'b1;
                  // LL takes priority: it re-arms the link whatever else happened.
                  if (dREN && datomic) begin
                     link_valid <= 1'b1;
                     link_addr  <= daddr;
                  end else if (dWEN && datomic) begin
                     link_valid <= 1'b0;
                  end else if (dWEN && (daddr == link_addr)) begin
                     link_valid <= 1'b0;
                  end
               end
            end
            SCFAIL: begin
               last_data  <= 1'b1;
               link_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Arbitration, next state and RAM/port outputs.
   // NOTE: every output is given a default before the case so no path leaves
   // one unassigned, which would otherwise infer a latch.
   always_comb begin
      next_state = state;
      ramREN     = 1'b0;
      ramWEN     = 1'b0;
      ramaddr    = 32'd0;
      ramstore   = 32'd0;
      iload      = 32'd0;
      dload      = 32'd0;
      case (state)
         IDLE: begin
            // Data wins a tie unless it won last time, so neither port starves.
            if (dreq && (!iREN || !last_data)) begin
               if (dWEN && datomic && !sc_link_ok) next_state = SCFAIL;
               else                                next_state = DACCESS;
            end else if (iREN) begin
               next_state = IFETCH;
            end
         end
         IFETCH: begin
            ramREN  = 1'b1;
            ramaddr = iaddr;
            if (ram_done) begin
               iload      = ramload;
               next_state = IDLE;
            end
         end
         DACCESS: begin
            ramREN   = dREN;
            ramWEN   = dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
            if (ram_done) begin
               next_state = IDLE;
               if (dREN)         dload = ramload;
               else if (datomic) dload = 32'd1;
            end
         end
         SCFAIL: begin
            // Link already broken: answer failure without a RAM cycle.
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios for fetch, contention, wait states,
// LL/SC and reset, then randomized traffic against a transaction-level model.
module tb_mem_arbiter;

   localparam logic [1:0] ST_FREE   = 2'd0;
   localparam logic [1:0] ST_BUSY   = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [1:0] ST_ERROR  = 2'd3;

   localparam int K_LW = 0;
   localparam int K_SW = 1;
   localparam int K_LL = 2;
   localparam int K_SC = 3;

   logic        CLK, RST;
   logic        iREN, iwait;
   logic [31:0] iaddr, iload;
   logic        dREN, dWEN, datomic, dwait;
   logic [31:0] daddr, dstore, dload;
   logic        ramREN, ramWEN;
   logic [31:0] ramaddr, ramstore, ramload;
   logic [1:0]  ramstate;

   int n_checks = 0;
   int n_errors = 0;

   mem_arbiter dut (
      .CLK      (CLK),
      .RST      (RST),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .iwait    (iwait),
      .iload    (iload),
      .dREN     (dREN),
      .dWEN     (dWEN),
      .datomic  (datomic),
      .daddr    (daddr),
      .dstore   (dstore),
      .dwait    (dwait),
      .dload    (dload),
      .ramREN   (ramREN),
      .ramWEN   (ramWEN),
      .ramaddr  (ramaddr),
      .ramstore (ramstore),
      .ramload  (ramload),
      .ramstate (ramstate)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   // One data transaction with a fixed number of BUSY cycles before ACCESS.
   task automatic data_op(input logic ren, input logic wen, input logic atomic,
                          input logic [31:0] addr, input logic [31:0] store,
                          input int busy, input logic [31:0] rdata,
                          output logic [31:0] load, output int waits,
                          output logic strobed, output logic wrote,
                          output logic [31:0] w_addr, output logic [31:0] w_data,
                          output logic addr_ok);
      int   n;
      logic done;
      load = 32'd0; waits = 0; strobed = 1'b0; wrote = 1'b0;
      w_addr = 32'd0; w_data = 32'd0; addr_ok = 1'b1; done = 1'b0; n = 0;
      dREN = ren; dWEN = wen; datomic = atomic; daddr = addr; dstore = store;
      for (int c = 0; c < 20 && !done; c++) begin
         #1;
         if (ramREN || ramWEN) begin
            strobed = 1'b1;
            if (ramaddr !== addr) addr_ok = 1'b0;
            if (n < busy) begin
               ramstate = ST_BUSY; ramload = 32'd0; n++;
            end else begin
               ramstate = ST_ACCESS; ramload = rdata;
               if (ramWEN) begin wrote = 1'b1; w_addr = ramaddr; w_data = ramstore; end
            end
         end else begin
            ramstate = ST_FREE;
         end
         @(negedge CLK);
         if (dwait) waits++;
         else begin done = 1'b1; load = dload; end
         next_cycle();
      end
      check("op_done", done, 1'b1);
      dREN = 1'b0; dWEN = 1'b0; datomic = 1'b0; ramstate = ST_FREE;
      next_cycle();
   endtask

   // Transaction-level reference state for the random phase.
   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] env_mem [logic [31:0]];

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return a ^ 32'hA5A5_0000;
   endfunction

   function automatic logic [31:0] env_rd(input logic [31:0] a);
      if (env_mem.exists(a)) return env_mem[a];
      return a ^ 32'hA5A5_0000;
   endfunction

   typedef enum {O_NONE, O_INSTR, O_DATA, O_SCFAIL} owner_e;

   logic [31:0] ld, wa, wd;
   int          wc;
   logic        sb, wr, aok;

   owner_e      owner;
   logic        m_last_data, m_link_valid;
   logic [31:0] m_link_addr;
   logic        r_ireq, r_dreq, acc, is_rd;
   logic [31:0] r_iaddr, r_daddr, r_dstore;
   int          r_kind;
   logic        env_active;
   int          env_busy_left;

   initial begin
      RST = 1'b1; iREN = 1'b0; iaddr = 32'd0; dREN = 1'b0; dWEN = 1'b0;
      datomic = 1'b0; daddr = 32'd0; dstore = 32'd0;
      ramload = 32'd0; ramstate = ST_FREE;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;

      // Reset state
      @(negedge CLK);
      check("rst_ren", ramREN, 1'b0);
      check("rst_wen", ramWEN, 1'b0);
      check("rst_addr", ramaddr, 32'd0);
      check("rst_iwait", iwait, 1'b0);
      check("rst_dwait", dwait, 1'b0);
      next_cycle();

      // Single fetch
      iREN = 1'b1; iaddr = 32'h100;
      @(negedge CLK);
      check("f1_iwait", iwait, 1'b1);
      check("f1_ren", ramREN, 1'b0);
      next_cycle();
      ramstate = ST_ACCESS; ramload = 32'h2408_000A;
      @(negedge CLK);
      check("f2_ren", ramREN, 1'b1);
      check("f2_addr", ramaddr, 32'h100);
      check("f2_iwait", iwait, 1'b0);
      check("f2_iload", iload, 32'h2408_000A);
      next_cycle();
      iREN = 1'b0; ramstate = ST_FREE;
      @(negedge CLK);
      check("f3_ren", ramREN, 1'b0);
      next_cycle();

      // Contention: data first, then fetch, then data again
      iREN = 1'b1; iaddr = 32'h104; dREN = 1'b1; daddr = 32'h200;
      @(negedge CLK);
      check("c1_iwait", iwait, 1'b1);
      check("c1_dwait", dwait, 1'b1);
      check("c1_ren", ramREN, 1'b0);
      next_cycle();
      ramstate = ST_ACCESS; ramload = 32'h11;
      @(negedge CLK);
      check("c2_addr", ramaddr, 32'h200);
      check("c2_dwait", dwait, 1'b0);
      check("c2_dload", dload, 32'h11);
      check("c2_iwait", iwait, 1'b1);
      next_cycle();
      ramstate = ST_FREE;
      @(negedge CLK);
      check("c3_ren", ramREN, 1'b0);
      next_cycle();
      ramstate = ST_ACCESS; ramload = 32'h22;
      @(negedge CLK);
      check("c4_addr", ramaddr, 32'h104);
      check("c4_iwait", iwait, 1'b0);
      check("c4_iload", iload, 32'h22);
      check("c4_dwait", dwait, 1'b1);
      next_cycle();
      ramstate = ST_FREE;
      @(negedge CLK);
      check("c5_ren", ramREN, 1'b0);
      next_cycle();
      ramstate = ST_ACCESS; ramload = 32'h33;
      @(negedge CLK);
      check("c6_addr", ramaddr, 32'h200);
      check("c6_dwait", dwait, 1'b0);
      next_cycle();
      iREN = 1'b0; dREN = 1'b0; ramstate = ST_FREE;
      next_cycle();

      // Wait states: LW with 3 BUSY cycles
      data_op(1'b1, 1'b0, 1'b0, 32'h200, 32'd0, 3, 32'hDEAD_BEEF, ld, wc, sb, wr, wa, wd, aok);
      check("ws_dload", ld, 32'hDEAD_BEEF);
      check("ws_waits", wc, 4);
      check("ws_addr_stable", aok, 1'b1);

      // LL/SC success, then a repeated SC fails
      data_op(1'b1, 1'b0, 1'b1, 32'h300, 32'd0, 0, 32'h77, ld, wc, sb, wr, wa, wd, aok);
      data_op(1'b0, 1'b1, 1'b1, 32'h300, 32'd5, 0, 32'd0, ld, wc, sb, wr, wa, wd, aok);
      check("sc1_dload", ld, 32'd1);
      check("sc1_wrote", wr, 1'b1);
      check("sc1_waddr", wa, 32'h300);
      check("sc1_wdata", wd, 32'd5);
      data_op(1'b0, 1'b1, 1'b1, 32'h300, 32'd6, 0, 32'd0, ld, wc, sb, wr, wa, wd, aok);
      check("sc2_dload", ld, 32'd0);
      check("sc2_strobe", sb, 1'b0);
      check("sc2_waits", wc, 1);

      // Link broken by a store to the linked address
      data_op(1'b1, 1'b0, 1'b1, 32'h300, 32'd0, 0, 32'h1, ld, wc, sb, wr, wa, wd, aok);
      data_op(1'b0, 1'b1, 1'b0, 32'h300, 32'd9, 1, 32'd0, ld, wc, sb, wr, wa, wd, aok);
      data_op(1'b0, 1'b1, 1'b1, 32'h300, 32'd8, 0, 32'd0, ld, wc, sb, wr, wa, wd, aok);
      check("brk_dload", ld, 32'd0);
      check("brk_strobe", sb, 1'b0);

      // Store elsewhere leaves the link intact
      data_op(1'b1, 1'b0, 1'b1, 32'h300, 32'd0, 0, 32'h1, ld, wc, sb, wr, wa, wd, aok);
      data_op(1'b0, 1'b1, 1'b0, 32'h304, 32'd9, 0, 32'd0, ld, wc, sb, wr, wa, wd, aok);
      data_op(1'b0, 1'b1, 1'b1, 32'h300, 32'd8, 2, 32'd0, ld, wc, sb, wr, wa, wd, aok);
      check("keep_dload", ld, 32'd1);
      check("keep_wrote", wr, 1'b1);

      // Reset in the middle of a BUSY SC access
      data_op(1'b1, 1'b0, 1'b1, 32'h300, 32'd0, 0, 32'h1, ld, wc, sb, wr, wa, wd, aok);
      dWEN = 1'b1; datomic = 1'b1; daddr = 32'h300; dstore = 32'd7;
      next_cycle();
      ramstate = ST_BUSY; RST = 1'b1;
      @(negedge CLK);
      check("mr_pre_wen", ramWEN, 1'b1);
      next_cycle();
      @(negedge CLK);
      check("mr_post_wen", ramWEN, 1'b0);
      check("mr_post_ren", ramREN, 1'b0);
      check("mr_post_dwait", dwait, 1'b1);
      next_cycle();
      RST = 1'b0; dWEN = 1'b0; datomic = 1'b0; ramstate = ST_FREE;
      next_cycle();
      data_op(1'b0, 1'b1, 1'b1, 32'h300, 32'd7, 0, 32'd0, ld, wc, sb, wr, wa, wd, aok);
      check("mr_sc_dload", ld, 32'd0);
      check("mr_sc_strobe", sb, 1'b0);

      // Randomized traffic against the transaction-level model
      RST = 1'b1;
      next_cycle();
      RST = 1'b0;
      owner = O_NONE; m_last_data = 1'b0; m_link_valid = 1'b0; m_link_addr = 32'd0;
      r_ireq = 1'b0; r_dreq = 1'b0; r_iaddr = 32'd0; r_daddr = 32'd0; r_dstore = 32'd0;
      r_kind = K_LW; env_active = 1'b0; env_busy_left = 0;

      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (!r_ireq && ($urandom_range(0, 1) == 1)) begin
            r_ireq = 1'b1;
            r_iaddr = 32'h100 + 32'(4 * $urandom_range(0, 7));
         end
         if (!r_dreq && ($urandom_range(0, 1) == 1)) begin
            r_dreq = 1'b1;
            r_kind = int'($urandom_range(0, 3));
            r_daddr = 32'h300 + 32'(4 * $urandom_range(0, 3));
            r_dstore = $urandom;
         end
         iREN = r_ireq; iaddr = r_iaddr;
         dREN = r_dreq && (r_kind == K_LW || r_kind == K_LL);
         dWEN = r_dreq && (r_kind == K_SW || r_kind == K_SC);
         datomic = r_dreq && (r_kind == K_LL || r_kind == K_SC);
         daddr = r_daddr; dstore = r_dstore;
         #1;
         // RAM environment: random BUSY/ERROR stalls, then ACCESS
         if (ramREN || ramWEN) begin
            if (!env_active) begin
               env_active = 1'b1;
               env_busy_left = int'($urandom_range(0, 3));
            end
            if (env_busy_left > 0) begin
               env_busy_left--;
               ramstate = ($urandom_range(0, 3) == 0) ? ST_ERROR : ST_BUSY;
               ramload = $urandom;
            end else begin
               ramstate = ST_ACCESS;
               ramload = env_rd(ramaddr);
               env_active = 1'b0;
               if (ramWEN) env_mem[ramaddr] = ramstore;
            end
         end else begin
            ramstate = ST_FREE;
            ramload = $urandom;
         end
         acc = (ramstate == ST_ACCESS);
         @(negedge CLK);
         case (owner)
            O_NONE: begin
               check("idle_ren", ramREN, 1'b0);
               check("idle_wen", ramWEN, 1'b0);
               check("idle_iwait", iwait, r_ireq);
               check("idle_dwait", dwait, r_dreq);
               if (r_dreq && (!r_ireq || !m_last_data)) begin
                  if (r_kind == K_SC && !(m_link_valid && m_link_addr == r_daddr)) owner = O_SCFAIL;
                  else owner = O_DATA;
               end else if (r_ireq) begin
                  owner = O_INSTR;
               end
            end
            O_INSTR: begin
               check("if_ren", ramREN, 1'b1);
               check("if_wen", ramWEN, 1'b0);
               check("if_addr", ramaddr, r_iaddr);
               check("if_iwait", iwait, !acc);
               check("if_dwait", dwait, r_dreq);
               if (acc) begin
                  check("if_load", iload, ref_rd(r_iaddr));
                  m_last_data = 1'b0; owner = O_NONE; r_ireq = 1'b0;
               end
            end
            O_DATA: begin
               is_rd = (r_kind == K_LW || r_kind == K_LL);
               check("d_ren", ramREN, is_rd);
               check("d_wen", ramWEN, !is_rd);
               check("d_addr", ramaddr, r_daddr);
               if (!is_rd) check("d_store", ramstore, r_dstore);
               check("d_dwait", dwait, !acc);
               check("d_iwait", iwait, r_ireq);
               if (acc) begin
                  if (is_rd) check("d_load", dload, ref_rd(r_daddr));
                  else if (r_kind == K_SC) check("sc_ok_load", dload, 32'd1);
                  if (!is_rd) ref_mem[r_daddr] = r_dstore;
                  if (r_kind == K_LL) begin
                     m_link_valid = 1'b1; m_link_addr = r_daddr;
                  end else if (r_kind == K_SC) begin
                     m_link_valid = 1'b0;
                  end else if (r_kind == K_SW && r_daddr == m_link_addr) begin
                     m_link_valid = 1'b0;
                  end
                  m_last_data = 1'b1; owner = O_NONE; r_dreq = 1'b0;
               end
            end
            O_SCFAIL: begin
               check("scf_ren", ramREN, 1'b0);
               check("scf_wen", ramWEN, 1'b0);
               check("scf_dwait", dwait, 1'b0);
               check("scf_dload", dload, 32'd0);
               check("scf_iwait", iwait, r_ireq);
               m_link_valid = 1'b0; m_last_data = 1'b1; owner = O_NONE; r_dreq = 1'b0;
            end
            default: owner = O_NONE;
         endcase
         next_cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter and sequencer for the single shared RAM port behind the pipeline. It serves the instruction-fetch port and the data port, which carries the memory access requested by the decoded instruction: LW/LL as reads, SW/SC as writes, LL/SC flagged atomic. The block owns the LL/SC link register and resolves store-conditional success or failure. One request is in flight at a time, and each requester sees a wait/ready handshake.

## Interface
- No parameters; address and data width fixed at 32.
- CLK  in  1  system clock, all state on rising edge.
- RST  in  1  reset, synchronous, active-high.
- iREN  in  1  instruction read request; held until iwait low.
- iaddr  in  32  instruction word address.
- iwait  out  1  instruction port stalled.
- iload  out  32  instruction read data, valid when iREN & !iwait.
- dREN  in  1  data read request (LW/LL).
- dWEN  in  1  data write request (SW/SC); never asserted together with dREN.
- datomic  in  1  qualifies dREN as LL, dWEN as SC.
- daddr  in  32  data address.
- dstore  in  32  write data.
- dwait  out  1  data port stalled.
- dload  out  32  read data; for SC, 32'd1 success / 32'd0 failure; valid when request & !dwait.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data, valid when ramstate==ACCESS.
- ramstate  in  2  0 FREE, 1 BUSY, 2 ACCESS (completes this cycle), 3 ERROR.

## Operation
- FSM states: IDLE, IFETCH, DACCESS, SCFAIL.
- Registers: state, last_data (last grant was data), link_valid, link_addr[31:0].
- IDLE arbitration, evaluated each cycle:
  - Data request and no instruction request -> grant data.
  - Instruction request only -> IFETCH.
  - Both requests: data wins unless last_data=1, then IFETCH. Neither port starves.
  - A data grant goes to DACCESS, except SC (dWEN&datomic) with !(link_valid && link_addr==daddr), which goes to SCFAIL.
- IFETCH: ramREN=1, ramaddr=iaddr. On ramstate==ACCESS: iload=ramload, iwait=0, last_data<=0, -> IDLE.
- DACCESS: ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore. On ramstate==ACCESS: dwait=0, last_data<=1, -> IDLE. dload is then:
  - read: ramload.
  - SC: 32'd1.
- SCFAIL: no RAM strobe; dwait=0, dload=32'd0, last_data<=1, -> IDLE (one cycle).
- ramstate BUSY, FREE or ERROR while granted: hold state and strobes, wait stays high. ERROR is not a completion.
- Link register, updated on completion:
  - LL completing: link_valid<=1, link_addr<=daddr.
  - SC success: link_valid<=0.
  - SC failure: link_valid<=0.
  - Non-atomic write completing with daddr==link_addr: link_valid<=0.
  - LL completing wins over any clear in the same cycle.
- Waits: iwait = iREN & !(state==IFETCH & ramstate==ACCESS). dwait = (dREN|dWEN) & !((state==DACCESS & ramstate==ACCESS) | state==SCFAIL).
- Idle outputs: ramREN=ramWEN=0, ramaddr=0, ramstore=0, iload=dload=0.

## Timing
- Reset: state=IDLE, last_data=0, link_valid=0, link_addr=0. RAM strobes low the cycle after RST is sampled.
- Reset mid-access abandons the transfer. Waits follow the formulas from IDLE.
- Minimum latency is 2 cycles: request seen in IDLE in cycle k, strobe in k+1, wait low in k+1 if ACCESS that cycle.
- Each extra BUSY cycle adds one cycle.
- SC failure latency: wait low in cycle k+1, with no RAM activity.
- The arbiter returns to IDLE after every completion, so back-to-back grants are separated by one IDLE cycle.
- Requesters keep request, address and data stable until their wait drops. The arbiter never registers address or data.

## Test plan
- Single fetch: iREN=1, iaddr=0x100, ramstate ACCESS in 2nd cycle with ramload=0x2408000A -> iwait low cycle 2, iload=0x2408000A, ramREN high only cycle 2.
- Contention: iREN and dREN together from reset -> data served first. Both held -> fetch served next even while dREN stays asserted. Alternation continues.
- Wait states: LW daddr=0x200 with 3 BUSY cycles then ACCESS, ramload=0xDEADBEEF -> dwait high 4 cycles, dload=0xDEADBEEF, ramaddr stable throughout.
- LL/SC success: LL 0x300, then SC 0x300 dstore=5 -> ramWEN pulse at 0x300 with 5, dload=1. A second SC at 0x300 -> dload=0, no ramWEN.
- Link break: LL 0x300, SW 0x300, SC 0x300 -> SC fails, dload=0. LL 0x300, SW 0x304, SC 0x300 -> succeeds.
- Reset mid-access: assert RST during DACCESS BUSY -> ramREN/ramWEN low next cycle, link_valid cleared, so the following SC fails.
